// File: rtl/debug_regfile_slave.sv
// Debug-bus responder: NUM_REGS x DATA_WIDTH register bank, reg[0][0] drives halt_o.
// Grant WAIT_CYCLES after req_i is first seen, rvalid_o one cycle after grant; the master stalls on gnt_o.
module debug_regfile_slave #(
   parameter int ADDR_WIDTH  = 15,
   parameter int DATA_WIDTH  = 65,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  we_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  halt_o,
   output logic                  err_o,
   input  logic                  err_clr_i
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   logic [IDX_W-1:0]      idx;
   logic [ADDR_WIDTH-1:0] addr_hi;
   logic                  in_range;
   logic                  gnt;

   // Any address bit above the index field makes the access out of range.
   assign idx      = addr_i[IDX_W+2:3];
   assign addr_hi  = addr_i >> (IDX_W + 3);
   assign in_range = (addr_hi == '0);

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_WAIT: begin
            if (!req_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            if (!req_i) begin
               state_d = S_IDLE;
            end else if (WAIT_CYCLES == 0) begin
               state_d = S_RESP;
            end else begin
               state_d = S_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
      endcase
   end

   // Output logic
   always_comb begin
      gnt = 1'b0;
      case (state_q)
         S_WAIT:  gnt = req_i && (cnt_q == '0);
         default: gnt = req_i && (WAIT_CYCLES == 0);
      endcase
   end

   // Datapath: register bank, read data and sticky error update on the grant edge.
   always_comb begin
      regs_d   = regs_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      rvalid_d = gnt;
      if (err_clr_i) begin
         err_d = 1'b0;
      end
      if (gnt) begin
         if (!in_range) begin
            err_d = 1'b1;
         end
         if (we_i) begin
            rdata_d = '0;
            if (in_range) begin
               regs_d[idx] = wdata_i;
            end
         end else begin
            rdata_d = in_range ? regs_q[idx] : '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign gnt_o    = gnt;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign halt_o   = regs_q[0][0];

endmodule

// File: tb/tb_debug_regfile_slave.sv
// Directed bench for debug_regfile_slave at grant latencies 1, 0 and 3.
module tb_debug_regfile_slave;

   localparam logic [64:0] DEAD = 65'h1_DEAD_BEEF_0000_0001;
   localparam logic [64:0] TOP  = 65'h1_0000_0000_0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // W=1 instance
   logic        req1 = 0, we1 = 0, clr1 = 0, gnt1, rvalid1, halt1, err1;
   logic [14:0] addr1 = '0;
   logic [64:0] wdata1 = '0, rdata1;
   // W=0 instance
   logic        req0 = 0, we0 = 0, clr0 = 0, gnt0, rvalid0, halt0, err0;
   logic [14:0] addr0 = '0;
   logic [64:0] wdata0 = '0, rdata0;
   // W=3 instance
   logic        req3 = 0, we3 = 0, clr3 = 0, gnt3, rvalid3, halt3, err3;
   logic [14:0] addr3 = '0;
   logic [64:0] wdata3 = '0, rdata3;

   debug_regfile_slave #(.WAIT_CYCLES(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req1), .gnt_o(gnt1), .rvalid_o(rvalid1),
      .addr_i(addr1), .we_i(we1), .wdata_i(wdata1), .rdata_o(rdata1),
      .halt_o(halt1), .err_o(err1), .err_clr_i(clr1));

   debug_regfile_slave #(.WAIT_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req0), .gnt_o(gnt0), .rvalid_o(rvalid0),
      .addr_i(addr0), .we_i(we0), .wdata_i(wdata0), .rdata_o(rdata0),
      .halt_o(halt0), .err_o(err0), .err_clr_i(clr0));

   debug_regfile_slave #(.WAIT_CYCLES(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .req_i(req3), .gnt_o(gnt3), .rvalid_o(rvalid3),
      .addr_i(addr3), .we_i(we3), .wdata_i(wdata3), .rdata_o(rdata3),
      .halt_o(halt3), .err_o(err3), .err_clr_i(clr3));

   typedef struct {
      logic        we;
      logic [14:0] addr;
      logic [64:0] wdata;
      logic        clr;
      logic [64:0] exp_rdata;
      logic        exp_err;
      logic        exp_halt;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [64:0] pat(input int i);
      return {1'b1, 32'hC0DE_0000 + 32'(i), 32'(i * 7 + 1)};
   endfunction

   // One complete transaction on the W=1 instance, starting just after a falling edge.
   task automatic access(input string nm, input logic w, input logic [14:0] a,
                         input logic [64:0] wd, input logic clr,
                         input logic [64:0] exp_rd, input logic exp_err, input logic exp_halt);
      int k;
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = wd; clr1 = clr;
      k = 0;
      #1;
      while (!gnt1 && k < 8) begin
         @(negedge clk); #1;
         k++;
      end
      chk({nm, " latency"}, 65'(k), 65'd1);
      if (gnt1) begin
         @(negedge clk);
         req1 = 1'b0; we1 = 1'b0; clr1 = 1'b0;
         #1;
         chk({nm, " rvalid"}, 65'(rvalid1), 65'd1);
         chk({nm, " rdata"}, rdata1, exp_rd);
         chk({nm, " err"}, 65'(err1), 65'(exp_err));
         chk({nm, " halt"}, 65'(halt1), 65'(exp_halt));
         @(negedge clk); #1;
         chk({nm, " rvalid fall"}, 65'(rvalid1), 65'd0);
         chk({nm, " rdata hold"}, rdata1, exp_rd);
      end else begin
         req1 = 1'b0; we1 = 1'b0; clr1 = 1'b0;
      end
   endtask

   initial begin
      //          we    addr      wdata   clr   exp_rdata exp_err exp_halt
      vecs[0]  = '{1'b1, 15'h0008, DEAD,   1'b0, 65'd0,    1'b0,   1'b0};
      vecs[1]  = '{1'b0, 15'h0008, 65'd0,  1'b0, DEAD,     1'b0,   1'b0};
      vecs[2]  = '{1'b1, 15'h0000, 65'd1,  1'b0, 65'd0,    1'b0,   1'b1};
      vecs[3]  = '{1'b0, 15'h0000, 65'd0,  1'b0, 65'd1,    1'b0,   1'b1};
      vecs[4]  = '{1'b1, 15'h0000, 65'd0,  1'b0, 65'd0,    1'b0,   1'b0};
      vecs[5]  = '{1'b0, 15'h0080, 65'd0,  1'b0, 65'd0,    1'b1,   1'b0};
      vecs[6]  = '{1'b0, 15'h0008, 65'd0,  1'b1, DEAD,     1'b0,   1'b0};
      vecs[7]  = '{1'b1, 15'h0088, 65'd5,  1'b0, 65'd0,    1'b1,   1'b0};
      vecs[8]  = '{1'b0, 15'h0008, 65'd0,  1'b0, DEAD,     1'b1,   1'b0};
      vecs[9]  = '{1'b0, 15'h4000, 65'd0,  1'b1, 65'd0,    1'b1,   1'b0};
      vecs[10] = '{1'b0, 15'h0010, 65'd0,  1'b1, 65'd0,    1'b0,   1'b0};
      vecs[11] = '{1'b1, 15'h0078, TOP,    1'b0, 65'd0,    1'b0,   1'b0};
      vecs[12] = '{1'b0, 15'h007F, 65'd0,  1'b0, TOP,      1'b0,   1'b0};
      vecs[13] = '{1'b0, 15'h0010, 65'd0,  1'b0, 65'd0,    1'b0,   1'b0};

      // Reset state
      #2;
      chk("reset gnt", 65'(gnt1), 65'd0);
      chk("reset rvalid", 65'(rvalid1), 65'd0);
      chk("reset rdata", rdata1, 65'd0);
      chk("reset halt", 65'(halt1), 65'd0);
      chk("reset err", 65'(err1), 65'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 14; v++) begin
         access($sformatf("vec%0d", v), vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].clr,
                vecs[v].exp_rdata, vecs[v].exp_err, vecs[v].exp_halt);
      end

      // Reset pulsed while a request sits in WAIT
      access("pre-rst halt", 1'b1, 15'h0000, 65'd1, 1'b0, 65'd0, 1'b0, 1'b1);
      access("pre-rst bad", 1'b0, 15'h0080, 65'd0, 1'b0, 65'd0, 1'b1, 1'b1);
      access("pre-rst rd", 1'b0, 15'h0078, 65'd0, 1'b0, TOP, 1'b1, 1'b1);
      req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0008;
      @(negedge clk); #1;
      chk("mid-wait gnt", 65'(gnt1), 65'd1);
      rst = 1'b1;
      #1;
      chk("rst gnt", 65'(gnt1), 65'd0);
      chk("rst rvalid", 65'(rvalid1), 65'd0);
      chk("rst rdata", rdata1, 65'd0);
      chk("rst halt", 65'(halt1), 65'd0);
      chk("rst err", 65'(err1), 65'd0);
      @(negedge clk);
      rst = 1'b0; req1 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("no late rvalid", 65'(rvalid1), 65'd0);
         @(negedge clk);
      end
      access("post-rst rd", 1'b0, 15'h0008, 65'd0, 1'b0, 65'd0, 1'b0, 1'b0);

      // W=0: 8 back-to-back writes then 8 back-to-back reads
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         if (c < 8) begin
            req0 = 1'b1; we0 = 1'b1; addr0 = 15'(c * 8); wdata0 = pat(c);
         end else if (c < 16) begin
            req0 = 1'b1; we0 = 1'b0; addr0 = 15'((c - 8) * 8);
         end else begin
            req0 = 1'b0; we0 = 1'b0;
         end
         #1;
         chk($sformatf("b2b gnt c%0d", c), 65'(gnt0), 65'(c < 16));
         chk($sformatf("b2b rvalid c%0d", c), 65'(rvalid0), 65'(c >= 1 && c <= 16));
         if (c >= 1 && c <= 8) chk($sformatf("b2b wr rdata c%0d", c), rdata0, 65'd0);
         if (c >= 9 && c <= 16) chk($sformatf("b2b rd rdata c%0d", c), rdata0, pat(c - 9));
      end

      // W=3: write reg1, aborted write, then read back
      @(negedge clk);
      req3 = 1'b1; we3 = 1'b1; addr3 = 15'h0008; wdata3 = 65'd7;
      for (int c = 0; c < 5; c++) begin
         if (c == 4) begin req3 = 1'b0; we3 = 1'b0; end
         #1;
         chk($sformatf("w3 wr gnt c%0d", c), 65'(gnt3), 65'(c == 3));
         chk($sformatf("w3 wr rvalid c%0d", c), 65'(rvalid3), 65'(c == 4));
         @(negedge clk);
      end
      req3 = 1'b1; we3 = 1'b1; addr3 = 15'h0008; wdata3 = 65'd9;
      for (int c = 0; c < 6; c++) begin
         if (c == 2) begin req3 = 1'b0; we3 = 1'b0; end
         #1;
         chk($sformatf("abort gnt c%0d", c), 65'(gnt3), 65'd0);
         chk($sformatf("abort rvalid c%0d", c), 65'(rvalid3), 65'd0);
         @(negedge clk);
      end
      req3 = 1'b1; we3 = 1'b0; addr3 = 15'h0008;
      for (int c = 0; c < 5; c++) begin
         if (c == 4) req3 = 1'b0;
         #1;
         chk($sformatf("w3 rd gnt c%0d", c), 65'(gnt3), 65'(c == 3));
         chk($sformatf("w3 rd rvalid c%0d", c), 65'(rvalid3), 65'(c == 4));
         if (c == 4) chk("w3 rd rdata", rdata3, 65'd7);
         @(negedge clk);
      end
      chk("w3 err", 65'(err3), 65'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
